// File: rtl/uart_crc_frame_tx_if.sv
// User-side bundle for the CRC frame transmitter: request, payload and status.
// The master side (user logic / bench) drives start and data_in; the slave
// side (the transmitter) drives the line and the status outputs.
interface uart_crc_frame_tx_if;
  logic        start;
  logic [31:0] data_in;
  logic        tx;
  logic        busy;
  logic        done;
  logic [7:0]  crc_out;

  modport master (
    output start,
    output data_in,
    input  tx,
    input  busy,
    input  done,
    input  crc_out
  );

  modport slave (
    input  start,
    input  data_in,
    output tx,
    output busy,
    output done,
    output crc_out
  );
endinterface

// File: rtl/uart_crc_frame_tx.sv
// UART 8N1 frame transmitter: four payload bytes (byte0 first, LSB first)
// followed by a CRC-8 byte (reflected poly 0x8C, init 0xFF, no final XOR).
// Bytes are sent back to back with no idle time between them.
module uart_crc_frame_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic              clk,
  input  logic              reset,
  uart_crc_frame_tx_if.slave bus
);

  localparam int                BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
  // The final cycle of a non-final stop bit is spent in NEXT_BYTE, so the
  // stop bit still lasts a full bit time on the line.
  localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]        CRC_BYTE     = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT_BYTE
  } state_t;

  // One byte of the reflected CRC-8 (poly 0x8C), unrolled over 8 bit steps.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        crc_out_q, crc_out_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        crc_q, crc_d;
  logic [7:0]        cur_byte;

  // Byte to be serialized next: payload bytes 0..3, then the running CRC.
  always_comb begin
    cur_byte = crc_q;
    case (byte_idx_q)
      3'd0:    cur_byte = shadow_q[7:0];
      3'd1:    cur_byte = shadow_q[15:8];
      3'd2:    cur_byte = shadow_q[23:16];
      3'd3:    cur_byte = shadow_q[31:24];
      default: cur_byte = crc_q;
    endcase
  end

  // Frame sequencer: next-state, line level, counters and CRC accumulation.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc_out_d  = crc_out_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d    = START_BIT;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          shadow_d   = bus.data_in;
          crc_d      = 8'hFF;
          byte_idx_d = 3'd0;
          bit_cnt_d  = 3'd0;
          baud_d     = '0;
        end
      end
      START_BIT: begin
        if (baud_q == BAUD_LAST) begin
          // Load the shifter at the end of the start bit; the top bit is the
          // stop level so the shifter drains into a 1 after the 8th bit.
          baud_d    = '0;
          state_d   = DATA_BITS;
          bit_cnt_d = 3'd0;
          tx_d      = cur_byte[0];
          shift_d   = {1'b1, cur_byte[7:1]};
          if (byte_idx_q != CRC_BYTE) begin
            crc_d = crc8_step(crc_q, cur_byte);
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA_BITS: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP_BIT: begin
        tx_d = 1'b1;
        if (byte_idx_q == CRC_BYTE && baud_q == BAUD_LAST) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          crc_out_d  = crc_q;
          baud_d     = '0;
          byte_idx_d = 3'd0;
        end else if (byte_idx_q != CRC_BYTE && baud_q == BAUD_PRELAST) begin
          state_d = NEXT_BYTE;
          baud_d  = baud_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      NEXT_BYTE: begin
        state_d    = START_BIT;
        tx_d       = 1'b0;
        baud_d     = '0;
        byte_idx_d = byte_idx_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_out_q  <= 8'h00;
      baud_q     <= '0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_out_q  <= crc_out_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Datapath registers; always reloaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    shift_q  <= shift_d;
    crc_q    <= crc_d;
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.crc_out = crc_out_q;

endmodule
